dual_issue_ctrl: RTL and testbench
==================================

DUAL_ISSUE_CTRL -- requirements
Module: dual_issue_ctrl

Interface
- REQ-001: Parameter NUM_REGS, default 128, is the number of architectural registers tracked.
- REQ-002: Parameter LAT_W, default 3, is the width of the producer-latency field.
- REQ-003: clk  input  1  is the single clock; all state updates on its rising edge.
- REQ-004: reset  input  1  is the asynchronous, active-low reset.
- REQ-005: i1_vld, i2_vld  input  1 each  flag a valid decoded instr1/instr2; instr1 is older.
- REQ-006: i1_pipe, i2_pipe  input  1 each  give the target pipe: 0 = even, 1 = odd.
- REQ-007: i1_wr, i2_wr  input  1 each  flag that the instruction writes rt.
- REQ-008: i1_rt, i2_rt  input  REG_ADDR_WIDTH each  give the destination register address.
- REQ-009: i1_src, i2_src  input  3*REG_ADDR_WIDTH each  give the {ra,rb,rc} addresses; i1_use, i2_use  input  3 each  give per-source valid bits.
- REQ-010: i1_lat, i2_lat  input  LAT_W each  give the producer result-ready latency in cycles, range 2..7.
- REQ-011: flush  input  1  is the branch-mispredict flush.
- REQ-012: dep_stall_instr1, dep_stall_instr2  output  1 each  are combinational holds to fetch/decode.
- REQ-013: even_vld, odd_vld  output  1 each  are registered issue-valid bits for each pipe.
- REQ-014: even_sel, odd_sel  output  1 each  are registered slot selects: 0 = instr1, 1 = instr2.

Function
- REQ-015: The scoreboard SHALL hold one LAT_W counter per register; a register is busy while its counter is non-zero.
- REQ-016: Issuing a writer SHALL load the counter for rt with lat-1; a consumer issued lat cycles after its producer sees the register ready.
- REQ-017: Non-loaded non-zero counters SHALL decrement by 1 each cycle; a load SHALL take priority over a decrement of the same entry.
- REQ-018: The FSM SHALL have two states: PAIR (both slots eligible) and SECOND (instr1 already issued, only instr2 eligible).
- REQ-019: In PAIR, instr1 SHALL issue iff valid and all of its used sources are not busy; otherwise both dep_stall outputs SHALL assert and nothing issues.
- REQ-020: In PAIR, instr2 SHALL issue with instr1 iff all of the following hold; otherwise dep_stall_instr2 asserts:
  - instr1 issues;
  - the pipes differ;
  - no used source of instr2 is busy or equal to i1_rt while i1_wr=1;
  - it is not the case that both write the same rt.
- REQ-021: The FSM SHALL go PAIR -> SECOND when instr1 issues and a valid instr2 does not, and SECOND -> PAIR when instr2 issues.
- REQ-022: In SECOND, the i1 inputs SHALL be ignored, dep_stall_instr1 SHALL assert, and instr2 issues under its source-busy check alone.
- REQ-023: An invalid instr2 SHALL never block instr1 or cause a transition to SECOND.
- REQ-024: Issue outputs SHALL register one cycle after the issue decision; the sel bit SHALL identify the slot routed to each pipe.
- REQ-025: flush SHALL force the next state to PAIR, suppress issue in that cycle (vld outputs low next cycle), and leave scoreboard counters decrementing.
- REQ-026: Decode SHALL hold its outputs stable while the corresponding dep_stall is asserted; this block SHALL NOT buffer instructions.

Reset
- REQ-027: On reset low, the block SHALL asynchronously reach state PAIR, clear all counters, and drive even_vld=odd_vld=0 and even_sel=odd_sel=0.
- REQ-028: dep_stall outputs SHALL be 0 during reset, and reset mid-sequence SHALL discard any pending instr2.

Configuration
- REQ-029: When ISSUE_PERF_CNT_EN is defined, the block SHALL add 32-bit outputs dual_issue_cnt and stall_cnt:
  - dual_issue_cnt increments on each cycle both pipes issue;
  - stall_cnt increments on each cycle either dep_stall asserts;
  - both wrap at 2^32 and reset to 0.
- REQ-030: When ISSUE_PERF_CNT_EN is undefined, those ports and counters SHALL be absent, with all other behaviour identical.

Structure
- REQ-031: The pipe-select encoding, the FSM state enum and the latency constants for fx1=2, byte=3, fx2=3, sp_fp=6, sp_int=7, perm=3, ls=6 and branch=3 SHALL live in the shared constants package.
- REQ-032: The scoreboard counter array SHALL be the sub-module issue_scoreboard, with ports for 6 busy lookups and 2 load ports.

Verification
- REQ-033: Independent pair, instr1 even rt=5 lat=2 and instr2 odd rt=6 -> next cycle even_vld=odd_vld=1 with even_sel=0 and odd_sel=1, and no stall.
- REQ-034: Both instructions even -> instr1 issues and dep_stall_instr2=1; one cycle later instr2 issues with even_sel=1.
- REQ-035: Intra-pair RAW: instr1 writes r10 lat=6, instr2 (odd) reads r10 -> instr2 issues exactly 6 cycles after instr1.
- REQ-036: Busy source: r3 loaded with lat=7 and instr1 reading r3 -> both stalls held for 6 cycles, then issue in the 7th cycle.
- REQ-037: flush asserted while in SECOND -> no issue in the flush cycle and state returns to PAIR.
- REQ-038: Reset asserted mid-stall, then a reader of the previously busy register presented after reset -> it issues immediately.

Source files
------------

// File: rtl/dual_issue_ctrl_pkg.sv
// Shared constants for the dual-issue controller: pipe encoding, FSM states and
// producer latencies of each execution unit.
package dual_issue_ctrl_pkg;

   typedef enum logic {
      PIPE_EVEN = 1'b0,
      PIPE_ODD  = 1'b1
   } pipe_e;

   typedef enum logic {
      ST_PAIR   = 1'b0,
      ST_SECOND = 1'b1
   } issue_state_e;

   localparam int unsigned LAT_FX1    = 2;
   localparam int unsigned LAT_BYTE   = 3;
   localparam int unsigned LAT_FX2    = 3;
   localparam int unsigned LAT_SP_FP  = 6;
   localparam int unsigned LAT_SP_INT = 7;
   localparam int unsigned LAT_PERM   = 3;
   localparam int unsigned LAT_LS     = 6;
   localparam int unsigned LAT_BRANCH = 3;

endpackage

// File: rtl/dual_issue_ctrl_if.sv
// Decode-to-issue bus of the dual-issue controller: two decoded slots in,
// dependency holds and per-pipe issue selects out.
interface dual_issue_ctrl_if
   import dual_issue_ctrl_pkg::*;
#(
   parameter int NUM_REGS = 128,
   parameter int LAT_W    = 3
);
   localparam int REG_ADDR_WIDTH = $clog2(NUM_REGS);

   // Handshake: dep_stall_instrN is the inverse of ready for slot N. Decode holds
   // a slot stable while its stall is high; a valid slot is consumed in a cycle
   // where its stall is low. In SECOND, instr1 was consumed earlier and its stall
   // stays high only to freeze the pair until instr2 leaves.
   logic                        i1_vld, i2_vld;
   logic                        i1_pipe, i2_pipe;
   logic                        i1_wr, i2_wr;
   logic [REG_ADDR_WIDTH-1:0]   i1_rt, i2_rt;
   logic [3*REG_ADDR_WIDTH-1:0] i1_src, i2_src;
   logic [2:0]                  i1_use, i2_use;
   logic [LAT_W-1:0]            i1_lat, i2_lat;
   logic                        flush;
   logic                        dep_stall_instr1, dep_stall_instr2;
   logic                        even_vld, odd_vld;
   logic                        even_sel, odd_sel;
   issue_state_e                dbg_state;

   modport master (
      output i1_vld, i2_vld, i1_pipe, i2_pipe, i1_wr, i2_wr, i1_rt, i2_rt,
             i1_src, i2_src, i1_use, i2_use, i1_lat, i2_lat, flush,
      input  dep_stall_instr1, dep_stall_instr2, even_vld, odd_vld,
             even_sel, odd_sel, dbg_state
   );

   modport slave (
      input  i1_vld, i2_vld, i1_pipe, i2_pipe, i1_wr, i2_wr, i1_rt, i2_rt,
             i1_src, i2_src, i1_use, i2_use, i1_lat, i2_lat, flush,
      output dep_stall_instr1, dep_stall_instr2, even_vld, odd_vld,
             even_sel, odd_sel, dbg_state
   );

endinterface

// File: rtl/issue_scoreboard.sv
// Per-register result-latency counters; a register is busy while its counter
// is non-zero. Six read lookups, two load ports (port 1 wins on a clash).
module issue_scoreboard #(
   parameter int NUM_REGS = 128,
   parameter int LAT_W    = 3,
   parameter int AW       = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [5:0][AW-1:0]    rd_addr,
   output logic [5:0]            busy,
   input  logic [1:0]            ld_en,
   input  logic [1:0][AW-1:0]    ld_addr,
   input  logic [1:0][LAT_W-1:0] ld_val
);

   logic [LAT_W-1:0] cnt [NUM_REGS];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (ld_en[1] && ld_addr[1] == AW'(r))
               cnt[r] <= ld_val[1];
            else if (ld_en[0] && ld_addr[0] == AW'(r))
               cnt[r] <= ld_val[0];
            else if (cnt[r] != '0)
               cnt[r] <= cnt[r] - LAT_W'(1);
         end
      end
   end

   always_comb begin
      busy = '0;
      for (int k = 0; k < 6; k++) busy[k] = (cnt[rd_addr[k]] != '0);
   end

endmodule

// File: rtl/dual_issue_ctrl.sv
// In-order dual-issue controller for an even/odd pipe pair with a latency
// scoreboard. Optional perf counters are built when ISSUE_PERF_CNT_EN is defined.
module dual_issue_ctrl
   import dual_issue_ctrl_pkg::*;
#(
   parameter int NUM_REGS = 128,
   parameter int LAT_W    = 3
) (
   input  logic               clk,
   input  logic               reset,
   dual_issue_ctrl_if.slave   bus
`ifdef ISSUE_PERF_CNT_EN
   ,
   output logic [31:0]        dual_issue_cnt,
   output logic [31:0]        stall_cnt
`endif
);

   localparam int REG_ADDR_WIDTH = $clog2(NUM_REGS);

   issue_state_e                       state;
   logic [5:0][REG_ADDR_WIDTH-1:0]     rd_addr;
   logic [5:0]                         busy;
   logic [1:0]                         ld_en;
   logic [1:0][REG_ADDR_WIDTH-1:0]     ld_addr;
   logic [1:0][LAT_W-1:0]              ld_val;
   logic i1_src_busy, i2_src_busy, i2_raw, i2_waw;
   logic i1_ok, i2_pair_ok, i2_second_ok, in_pair;
   logic i1_iss, i2_iss, stall1, stall2;
   logic ev_vld_d, ev_sel_d, od_vld_d, od_sel_d;

   // Lookups 0..2 are instr1 {rc,rb,ra}, 3..5 the same for instr2.
   assign rd_addr = {bus.i2_src, bus.i1_src};
   assign ld_addr = {bus.i2_rt, bus.i1_rt};
   assign ld_val  = {bus.i2_lat - LAT_W'(1), bus.i1_lat - LAT_W'(1)};
   assign ld_en   = {i2_iss && bus.i2_wr, i1_iss && bus.i1_wr};

   issue_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .LAT_W    (LAT_W),
      .AW       (REG_ADDR_WIDTH)
   ) u_sb (
      .clk     (clk),
      .reset   (reset),
      .rd_addr (rd_addr),
      .busy    (busy),
      .ld_en   (ld_en),
      .ld_addr (ld_addr),
      .ld_val  (ld_val)
   );

   always_comb begin
      i2_raw = 1'b0;
      for (int k = 0; k < 3; k++)
         if (bus.i2_use[k] && bus.i1_wr && rd_addr[k+3] == bus.i1_rt) i2_raw = 1'b1;
   end

   assign i1_src_busy  = |(bus.i1_use & busy[2:0]);
   assign i2_src_busy  = |(bus.i2_use & busy[5:3]);
   assign i2_waw       = bus.i1_wr && bus.i2_wr && (bus.i1_rt == bus.i2_rt);
   assign in_pair      = (state == ST_PAIR);
   assign i1_ok        = bus.i1_vld && !i1_src_busy;
   assign i2_pair_ok   = i1_ok && bus.i2_vld && (bus.i1_pipe != bus.i2_pipe)
                         && !i2_src_busy && !i2_raw && !i2_waw;
   assign i2_second_ok = bus.i2_vld && !i2_src_busy;

   assign i1_iss = in_pair && i1_ok && !bus.flush;
   assign i2_iss = !bus.flush && (in_pair ? i2_pair_ok : i2_second_ok);

   // Stalls are forced low while reset is held so decode never sees a stale hold.
   assign stall1 = reset && (in_pair ? (bus.i1_vld && !i1_ok) : 1'b1);
   assign stall2 = reset && (in_pair ? ((bus.i1_vld && !i1_ok) || (bus.i2_vld && !i2_pair_ok))
                                     : (bus.i2_vld && !i2_second_ok));
   assign bus.dep_stall_instr1 = stall1;
   assign bus.dep_stall_instr2 = stall2;

   // Each slot goes to its own pipe; sel is 1 only when instr2 is routed there.
   assign ev_vld_d = (i1_iss && bus.i1_pipe == PIPE_EVEN) || (i2_iss && bus.i2_pipe == PIPE_EVEN);
   assign od_vld_d = (i1_iss && bus.i1_pipe == PIPE_ODD)  || (i2_iss && bus.i2_pipe == PIPE_ODD);
   assign ev_sel_d = i2_iss && bus.i2_pipe == PIPE_EVEN;
   assign od_sel_d = i2_iss && bus.i2_pipe == PIPE_ODD;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_PAIR;
         bus.even_vld <= 1'b0;
         bus.odd_vld  <= 1'b0;
         bus.even_sel <= 1'b0;
         bus.odd_sel  <= 1'b0;
      end else begin
         if (bus.flush)
            state <= ST_PAIR;
         else if (in_pair && i1_iss && bus.i2_vld && !i2_iss)
            state <= ST_SECOND;
         else if (!in_pair && i2_iss)
            state <= ST_PAIR;
         bus.even_vld <= ev_vld_d;
         bus.odd_vld  <= od_vld_d;
         bus.even_sel <= ev_sel_d;
         bus.odd_sel  <= od_sel_d;
      end
   end

   assign bus.dbg_state = state;

`ifdef ISSUE_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dual_issue_cnt <= '0;
         stall_cnt      <= '0;
      end else begin
         if (ev_vld_d && od_vld_d) dual_issue_cnt <= dual_issue_cnt + 32'd1;
         if (stall1 || stall2)     stall_cnt      <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Bench for dual_issue_ctrl: directed pair/stall/flush/reset scenarios plus a
// random independent-pair loop, checked through an expected-output queue.
module tb_dual_issue_ctrl;
   import dual_issue_ctrl_pkg::*;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_err;
   logic [4:0] exp_q[$];
   logic [4:0] mon_e;

`ifdef ISSUE_PERF_CNT_EN
   logic [31:0] dual_issue_cnt;
   logic [31:0] stall_cnt;
`endif

   dual_issue_ctrl_if #(.NUM_REGS(128), .LAT_W(3)) bus ();

   dual_issue_ctrl #(.NUM_REGS(128), .LAT_W(3)) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus)
`ifdef ISSUE_PERF_CNT_EN
      ,
      .dual_issue_cnt (dual_issue_cnt),
      .stall_cnt      (stall_cnt)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // driver tasks
   task automatic set_i1(input logic v, input logic p, input logic w, input logic [6:0] rt,
                         input logic [20:0] src, input logic [2:0] u, input logic [2:0] lat);
      bus.i1_vld = v; bus.i1_pipe = p; bus.i1_wr = w; bus.i1_rt = rt;
      bus.i1_src = src; bus.i1_use = u; bus.i1_lat = lat;
   endtask

   task automatic set_i2(input logic v, input logic p, input logic w, input logic [6:0] rt,
                         input logic [20:0] src, input logic [2:0] u, input logic [2:0] lat);
      bus.i2_vld = v; bus.i2_pipe = p; bus.i2_wr = w; bus.i2_rt = rt;
      bus.i2_src = src; bus.i2_use = u; bus.i2_lat = lat;
   endtask

   task automatic clear_slots();
      set_i1(1'b0, 1'b0, 1'b0, 7'd0, 21'd0, 3'd0, 3'd2);
      set_i2(1'b0, 1'b0, 1'b0, 7'd0, 21'd0, 3'd0, 3'd2);
   endtask

   // One clock: check the masked stalls for the current inputs, then queue the
   // registered outputs {state, even_vld, even_sel, odd_vld, odd_sel} expected after the edge.
   task automatic cycle(input logic [1:0] st_exp, input logic [1:0] st_mask, input logic [4:0] out_exp);
      #1;
      if (st_mask[1]) check("stall1", 32'(bus.dep_stall_instr1), 32'(st_exp[1]));
      if (st_mask[0]) check("stall2", 32'(bus.dep_stall_instr2), 32'(st_exp[0]));
      @(posedge clk);
      exp_q.push_back(out_exp);
      #1;
   endtask

   task automatic idle(input int n);
      clear_slots();
      bus.flush = 1'b0;
      for (int i = 0; i < n; i++) cycle(2'b00, 2'b00, 5'b0_0_0_0_0);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("issue", 32'({bus.dbg_state, bus.even_vld, bus.even_sel, bus.odd_vld, bus.odd_sel}),
               32'(mon_e));
      end
   end

   initial begin
      logic       p;
      logic [6:0] rt1, rt2;
      logic [20:0] s1, s2;
      logic [2:0] l1, l2;
      n_chk = 0;
      n_err = 0;
      reset = 1'b0;
      bus.flush = 1'b0;
      clear_slots();
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", 32'(bus.dbg_state), 32'(ST_PAIR));
      check("rst_vld", 32'({bus.even_vld, bus.odd_vld}), 32'd0);
      check("rst_sel", 32'({bus.even_sel, bus.odd_sel}), 32'd0);
      check("rst_stall", 32'({bus.dep_stall_instr1, bus.dep_stall_instr2}), 32'd0);
`ifdef ISSUE_PERF_CNT_EN
      check("rst_perf", dual_issue_cnt | stall_cnt, 32'd0);
`endif
      reset = 1'b1;
      idle(2);

      // independent pair
      set_i1(1'b1, 1'b0, 1'b1, 7'd5, 21'd0, 3'b000, 3'(LAT_FX1));
      set_i2(1'b1, 1'b1, 1'b1, 7'd6, 21'd0, 3'b000, 3'd2);
      cycle(2'b00, 2'b11, 5'b0_1_0_1_1);
      idle(2);

      // same pipe: instr2 follows one cycle later, instr1 inputs ignored in SECOND
      set_i1(1'b1, 1'b0, 1'b0, 7'd7, 21'd0, 3'b000, 3'd2);
      set_i2(1'b1, 1'b0, 1'b0, 7'd8, 21'd0, 3'b000, 3'd2);
      cycle(2'b01, 2'b11, 5'b1_1_0_0_0);
      cycle(2'b10, 2'b11, 5'b0_1_1_0_0);
      idle(1);

      // intra-pair RAW on r10, lat 6
      set_i1(1'b1, 1'b0, 1'b1, 7'd10, 21'd0, 3'b000, 3'(LAT_SP_FP));
      set_i2(1'b1, 1'b1, 1'b0, 7'd11, {7'd10, 14'd0}, 3'b100, 3'd2);
      cycle(2'b01, 2'b11, 5'b1_1_0_0_0);
      repeat (5) cycle(2'b11, 2'b11, 5'b1_0_0_0_0);
      cycle(2'b10, 2'b11, 5'b0_0_0_1_1);
      idle(1);

      // busy source r3 (lat 7), lone writer must not leave PAIR
      set_i1(1'b1, 1'b0, 1'b1, 7'd3, 21'd0, 3'b000, 3'(LAT_SP_INT));
      set_i2(1'b0, 1'b1, 1'b0, 7'd0, 21'd0, 3'b000, 3'd2);
      cycle(2'b00, 2'b10, 5'b0_1_0_0_0);
      set_i1(1'b1, 1'b0, 1'b0, 7'd12, {14'd0, 7'd3}, 3'b001, 3'd2);
      set_i2(1'b1, 1'b1, 1'b0, 7'd13, 21'd0, 3'b000, 3'd2);
      repeat (6) cycle(2'b11, 2'b11, 5'b0_0_0_0_0);
      cycle(2'b00, 2'b11, 5'b0_1_0_1_1);
      idle(1);

      // same destination: instr2 deferred to SECOND
      set_i1(1'b1, 1'b0, 1'b1, 7'd20, 21'd0, 3'b000, 3'd2);
      set_i2(1'b1, 1'b1, 1'b1, 7'd20, 21'd0, 3'b000, 3'd3);
      cycle(2'b01, 2'b11, 5'b1_1_0_0_0);
      cycle(2'b10, 2'b11, 5'b0_0_0_1_1);
      idle(3);

      // swapped pipes: instr1 odd, instr2 even
      set_i1(1'b1, 1'b1, 1'b0, 7'd1, 21'd0, 3'b000, 3'd2);
      set_i2(1'b1, 1'b0, 1'b0, 7'd2, 21'd0, 3'b000, 3'd2);
      cycle(2'b00, 2'b11, 5'b0_1_1_1_0);
      idle(1);

      // flush while in SECOND
      set_i1(1'b1, 1'b0, 1'b0, 7'd21, 21'd0, 3'b000, 3'd2);
      set_i2(1'b1, 1'b0, 1'b0, 7'd22, 21'd0, 3'b000, 3'd2);
      cycle(2'b01, 2'b11, 5'b1_1_0_0_0);
      bus.flush = 1'b1;
      cycle(2'b00, 2'b00, 5'b0_0_0_0_0);
      idle(1);

      // flushed writer does not mark its destination busy
      set_i1(1'b1, 1'b0, 1'b1, 7'd25, 21'd0, 3'b000, 3'd7);
      bus.flush = 1'b1;
      cycle(2'b00, 2'b00, 5'b0_0_0_0_0);
      bus.flush = 1'b0;
      set_i1(1'b1, 1'b0, 1'b0, 7'd26, {7'd25, 14'd0}, 3'b100, 3'd2);
      cycle(2'b00, 2'b10, 5'b0_1_0_0_0);
      idle(1);

      // reset while instr2 waits on r3
      set_i1(1'b1, 1'b0, 1'b1, 7'd3, 21'd0, 3'b000, 3'd7);
      set_i2(1'b1, 1'b1, 1'b0, 7'd14, {7'd3, 14'd0}, 3'b100, 3'd2);
      cycle(2'b01, 2'b11, 5'b1_1_0_0_0);
      repeat (2) cycle(2'b11, 2'b11, 5'b1_0_0_0_0);
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("mid_rst_state", 32'(bus.dbg_state), 32'(ST_PAIR));
      check("mid_rst_out", 32'({bus.even_vld, bus.even_sel, bus.odd_vld, bus.odd_sel}), 32'd0);
      check("mid_rst_stall", 32'({bus.dep_stall_instr1, bus.dep_stall_instr2}), 32'd0);
      set_i1(1'b1, 1'b1, 1'b0, 7'd15, {7'd3, 14'd0}, 3'b100, 3'd2);
      set_i2(1'b0, 1'b0, 1'b0, 7'd0, 21'd0, 3'b000, 3'd2);
      #1;
      reset = 1'b1;
      cycle(2'b00, 2'b10, 5'b0_0_0_1_0);
      idle(1);

      // random independent pairs on opposite pipes
      for (int i = 0; i < 8; i++) begin
         p   = 1'($urandom_range(0, 1));
         rt1 = 7'(32 + $urandom_range(0, 31));
         rt2 = 7'(64 + $urandom_range(0, 31));
         s1  = 21'($urandom_range(0, 2097151));
         s2  = 21'($urandom_range(0, 2097151));
         l1  = 3'($urandom_range(2, 7));
         l2  = 3'($urandom_range(2, 7));
         set_i1(1'b1, p, 1'($urandom_range(0, 1)), rt1, s1, 3'b000, l1);
         set_i2(1'b1, ~p, 1'($urandom_range(0, 1)), rt2, s2, 3'b000, l2);
         cycle(2'b00, 2'b11, p ? 5'b0_1_1_1_0 : 5'b0_1_0_1_1);
      end
      idle(1);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      check("drain", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
